// File: rtl/ext_pkg.sv
// Mode encodings and the parameter legality helper shared by the
// immediate extender top level and its combinational core.
package ext_pkg;

  localparam logic [1:0] MODE_ZERO  = 2'b00;
  localparam logic [1:0] MODE_SIGN  = 2'b01;
  localparam logic [1:0] MODE_UPPER = 2'b10;
  localparam logic [1:0] MODE_BOFF  = 2'b11;

  function automatic bit params_ok(input int in_w, input int out_w, input int depth);
    return (in_w >= 1) && (out_w >= in_w + 2) && (depth >= 1) && (depth <= 3);
  endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extension: (imm, mode) -> OUT_W-bit operand.
module imm_ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] ext
);

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;

  assign zext = {{(OUT_W-IN_W){1'b0}}, imm};
  assign sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

  always_comb begin
    ext = zext;
    case (mode)
      MODE_ZERO:  ext = zext;
      MODE_SIGN:  ext = sext;
      // shifting the zero-extended value drops anything above OUT_W
      MODE_UPPER: ext = zext << IN_W;
      MODE_BOFF:  ext = sext << 2;
      default:    ext = zext;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender for the ID/EX boundary: DEPTH stages of
// {valid, mode, data} sharing one stall/flush enable.
module imm_extend_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [IN_W-1:0]  Imm_in,
  input  logic [1:0]       Mode_in,
  input  logic             Valid_in,
  input  logic             Stall,
  input  logic             Flush,
  output logic             Ready_out,
  output logic [OUT_W-1:0] Imm_out,
  output logic             Valid_out,
  output logic [1:0]       Mode_out
);

  if (!params_ok(IN_W, OUT_W, DEPTH)) begin : g_bad_params
    $error("imm_extend_pipe: illegal parameters IN_W=%0d OUT_W=%0d DEPTH=%0d",
           IN_W, OUT_W, DEPTH);
  end

  // index 0 is the combinational stage-1 input; 1..DEPTH are registers
  logic             vld_pipe  [DEPTH:0];
  logic [1:0]       mode_pipe [DEPTH:0];
  logic [OUT_W-1:0] data_pipe [DEPTH:0];

  imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .imm  (Imm_in),
    .mode (Mode_in),
    .ext  (data_pipe[0])
  );

  assign vld_pipe[0]  = Valid_in;
  assign mode_pipe[0] = Mode_in;

  for (genvar s = 1; s <= DEPTH; s++) begin : g_stage
    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        vld_pipe[s]  <= 1'b0;
        mode_pipe[s] <= MODE_ZERO;
        data_pipe[s] <= '0;
      end else if (Flush) begin
        // flush outranks stall; data is left stale on purpose
        vld_pipe[s] <= 1'b0;
      end else if (!Stall) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        mode_pipe[s] <= mode_pipe[s-1];
        data_pipe[s] <= data_pipe[s-1];
      end
    end
  end

  assign Ready_out = ~Stall;
  assign Valid_out = vld_pipe[DEPTH];
  assign Mode_out  = mode_pipe[DEPTH];
  assign Imm_out   = data_pipe[DEPTH];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe across DEPTH 1/2/3 and a 12-bit input build.
module tb_imm_extend_pipe;

  logic        Clk, Rst_n;
  logic [15:0] imm16;
  logic [11:0] imm12;
  logic [1:0]  mode;
  logic        vin, stall, flush;

  logic        rdy1, rdy2, rdy3, rdy4;
  logic [31:0] out1, out2, out3, out4;
  logic        vo1, vo2, vo3, vo4;
  logic [1:0]  mo1, mo2, mo3, mo4;

  int tests = 0;
  int fails = 0;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(1)) dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .Imm_in(imm16), .Mode_in(mode), .Valid_in(vin),
    .Stall(stall), .Flush(flush), .Ready_out(rdy1), .Imm_out(out1),
    .Valid_out(vo1), .Mode_out(mo1));

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(2)) dut2 (
    .Clk(Clk), .Rst_n(Rst_n), .Imm_in(imm16), .Mode_in(mode), .Valid_in(vin),
    .Stall(stall), .Flush(flush), .Ready_out(rdy2), .Imm_out(out2),
    .Valid_out(vo2), .Mode_out(mo2));

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(3)) dut3 (
    .Clk(Clk), .Rst_n(Rst_n), .Imm_in(imm16), .Mode_in(mode), .Valid_in(vin),
    .Stall(stall), .Flush(flush), .Ready_out(rdy3), .Imm_out(out3),
    .Valid_out(vo3), .Mode_out(mo3));

  imm_extend_pipe #(.IN_W(12), .OUT_W(32), .DEPTH(1)) dut4 (
    .Clk(Clk), .Rst_n(Rst_n), .Imm_in(imm12), .Mode_in(mode), .Valid_in(vin),
    .Stall(stall), .Flush(flush), .Ready_out(rdy4), .Imm_out(out4),
    .Valid_out(vo4), .Mode_out(mo4));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] mode_exp [4] = '{32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004};
  logic [11:0] imm12_vec [4] = '{12'h800, 12'h800, 12'hABC, 12'hFFF};
  logic [31:0] w12_exp  [4] = '{32'h00000800, 32'hFFFFF800, 32'h00ABC000, 32'hFFFFFFFC};

  initial begin
    Rst_n = 1'b0; imm16 = '0; imm12 = '0; mode = 2'b00;
    vin = 1'b0; stall = 1'b0; flush = 1'b0;
    #1;
    check("reset_imm",   out1, 32'h0);
    check("reset_valid", {31'b0, vo1}, 32'h0);
    check("reset_mode",  {30'b0, mo1}, 32'h0);
    check("reset_v3",    {31'b0, vo3}, 32'h0);
    #11 Rst_n = 1'b1;

    // all four modes, plus the 12-bit build alongside
    for (int m = 0; m < 4; m++) begin
      imm16 = 16'h8001; imm12 = imm12_vec[m]; mode = 2'(m); vin = 1'b1;
      tick();
      check($sformatf("mode%0d_imm", m),   out1, mode_exp[m]);
      check($sformatf("mode%0d_valid", m), {31'b0, vo1}, 32'h1);
      check($sformatf("mode%0d_mode", m),  {30'b0, mo1}, 32'(m));
      check($sformatf("w12_mode%0d", m),   out4, w12_exp[m]);
    end
    check("ready_idle", {31'b0, rdy1}, 32'h1);

    // stall holds the captured entry while the input keeps changing
    imm16 = 16'h1234; mode = 2'b01; vin = 1'b1;
    tick();
    check("stall_issue", out1, 32'h00001234);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      imm16 = 16'h5555 + 16'(c); mode = 2'b00;
      tick();
      check($sformatf("stall_hold%0d", c),  out1, 32'h00001234);
      check($sformatf("stall_valid%0d", c), {31'b0, vo1}, 32'h1);
      check($sformatf("stall_ready%0d", c), {31'b0, rdy1}, 32'h0);
    end
    stall = 1'b0; vin = 1'b0;
    tick();
    check("stall_release_v", {31'b0, vo1}, 32'h0);

    // DEPTH=3: fill three entries, then flush while stalled
    mode = 2'b00; vin = 1'b1;
    for (int e = 0; e < 3; e++) begin
      imm16 = 16'h00A0 + 16'(e);
      tick();
    end
    check("d3_full_v", {31'b0, vo3}, 32'h1);
    check("d3_full_d", out3, 32'h000000A0);
    stall = 1'b1; flush = 1'b1; imm16 = 16'hDEAD;
    tick();
    stall = 1'b0; flush = 1'b0;
    check("flush_v0", {31'b0, vo3}, 32'h0);
    imm16 = 16'h0777; mode = 2'b01; vin = 1'b1;
    tick();
    vin = 1'b0;
    check("flush_v1", {31'b0, vo3}, 32'h0);
    tick();
    check("flush_v2", {31'b0, vo3}, 32'h0);
    tick();
    check("flush_emerge_v", {31'b0, vo3}, 32'h1);
    check("flush_emerge_d", out3, 32'h00000777);
    check("flush_emerge_m", {30'b0, mo3}, 32'h1);

    // DEPTH=2 back-to-back stream of eight
    flush = 1'b1;
    tick();
    flush = 1'b0;
    mode = 2'b00;
    for (int k = 1; k <= 10; k++) begin
      vin   = (k <= 8);
      imm16 = 16'h0100 + 16'(k - 1);
      tick();
      if (k >= 2 && k <= 9) begin
        check($sformatf("b2b_v%0d", k), {31'b0, vo2}, 32'h1);
        check($sformatf("b2b_d%0d", k), out2, 32'h00000100 + 32'(k - 2));
      end else begin
        check($sformatf("b2b_v%0d", k), {31'b0, vo2}, 32'h0);
      end
    end

    // asynchronous reset in the middle of traffic
    imm16 = 16'h4321; mode = 2'b10; vin = 1'b1;
    tick();
    check("pre_rst_v", {31'b0, vo1}, 32'h1);
    check("pre_rst_d", out1, 32'h43210000);
    #2 Rst_n = 1'b0;
    #1;
    check("async_rst_imm",  out1, 32'h0);
    check("async_rst_v",    {31'b0, vo1}, 32'h0);
    check("async_rst_mode", {30'b0, mo1}, 32'h0);
    check("async_rst_v2",   {31'b0, vo2}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
